// File: rtl/loteria_arbitro.sv
// Round-robin shared lottery bet checker: grants one terminal, collects 5 serial BCD digits,
// scores them against DRAW. Optional idle-digit watchdog enabled by defining LOTERIA_TIMEOUT_EN.
module loteria_arbitro #(
  parameter int unsigned          N_TERM      = 2,
  parameter int unsigned          DIGIT_W     = 4,
  parameter int unsigned          CNT_W       = 5,
  parameter logic [5*DIGIT_W-1:0] DRAW        = 20'h53820,
  parameter int unsigned          TIMEOUT_CYC = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_TERM-1:0]         req,
  input  logic [N_TERM*DIGIT_W-1:0] dig_in,
  input  logic [N_TERM-1:0]         dig_vld,
  input  logic                      clr_cnt,
  output logic [N_TERM-1:0]         grant,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                premio,
  output logic [2:0]                acertos,
  output logic [CNT_W-1:0]          p1,
  output logic [CNT_W-1:0]          p2,
  output logic                      aborted
);

  localparam int unsigned N_DIG = 5;
  localparam int unsigned IDX_W = $clog2(N_TERM);
  localparam int unsigned POS_W = 3;

  if (N_TERM < 2 || N_TERM > 8 || TIMEOUT_CYC == 0) begin : g_param_check
    $error("loteria_arbitro: unsupported parameter value");
  end

  typedef enum logic [1:0] {IDLE, COLLECT, EVAL} state_t;

  state_t             state_q, state_d;
  logic [N_TERM-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [N_DIG-1:0]   match_q, match_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [1:0]         premio_q, premio_d;
  logic [2:0]         acertos_q, acertos_d;
  logic [CNT_W-1:0]   p1_q, p1_d;
  logic [CNT_W-1:0]   p2_q, p2_d;

  logic [DIGIT_W-1:0] dig_g;
  logic [IDX_W-1:0]   gnext;
  logic [IDX_W-1:0]   pick;
  logic               req_any;
  logic [2:0]         run;
  logic [2:0]         pop;

`ifdef LOTERIA_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               aborted_q, aborted_d;
`endif

  assign dig_g = dig_in[32'(gidx_q)*DIGIT_W +: DIGIT_W];
  assign gnext = (gidx_q == IDX_W'(N_TERM-1)) ? '0 : gidx_q + IDX_W'(1);

  // First requester at or above ptr, wrapping modulo N_TERM.
  always_comb begin : p_arb
    logic [IDX_W-1:0] j;
    j       = '0;
    pick    = ptr_q;
    req_any = 1'b0;
    for (int unsigned i = 0; i < N_TERM; i++) begin
      j = IDX_W'((32'(ptr_q) + i) % N_TERM);
      if (!req_any && req[j]) begin
        pick    = j;
        req_any = 1'b1;
      end
    end
  end

  // Longest run of consecutive matches and total match count.
  always_comb begin : p_score
    logic [2:0] cur;
    cur = '0;
    run = '0;
    pop = '0;
    for (int unsigned k = 0; k < N_DIG; k++) begin
      if (match_q[k]) begin
        cur = cur + 3'd1;
        pop = pop + 3'd1;
      end else begin
        cur = '0;
      end
      if (cur > run) run = cur;
    end
  end

  always_comb begin : p_next
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    pos_d     = pos_q;
    match_d   = match_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    premio_d  = premio_q;
    acertos_d = acertos_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
`ifdef LOTERIA_TIMEOUT_EN
    wd_d      = wd_q;
    aborted_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d = COLLECT;
          gidx_d  = pick;
          grant_d = N_TERM'(1) << pick;
          busy_d  = 1'b1;
          pos_d   = '0;
          match_d = '0;
`ifdef LOTERIA_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end
      COLLECT: begin
        if (!req[gidx_q]) begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = gnext;
        end else if (dig_vld[gidx_q]) begin
          for (int unsigned k = 0; k < N_DIG; k++) begin
            if (pos_q == POS_W'(k))
              match_d[k] = (dig_g <= DIGIT_W'(9)) &&
                           (dig_g == DRAW[(N_DIG-1-k)*DIGIT_W +: DIGIT_W]);
          end
`ifdef LOTERIA_TIMEOUT_EN
          wd_d = '0;
`endif
          if (pos_q == POS_W'(N_DIG-1)) begin
            state_d = EVAL;
            grant_d = '0;
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end
`ifdef LOTERIA_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT_CYC-1)) begin
          state_d   = IDLE;
          grant_d   = '0;
          busy_d    = 1'b0;
          ptr_d     = gnext;
          aborted_d = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      EVAL: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        ptr_d     = gnext;
        acertos_d = pop;
        if (run >= 3'd4) begin
          premio_d = 2'b01;
          if (p1_q != '1) p1_d = p1_q + CNT_W'(1);
        end else if (run >= 3'd2) begin
          premio_d = 2'b10;
          if (p2_q != '1) p2_d = p2_q + CNT_W'(1);
        end else begin
          premio_d = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
    // Clear overrides a same-cycle increment.
    if (clr_cnt) begin
      p1_d = '0;
      p2_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      pos_q     <= '0;
      match_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      premio_q  <= '0;
      acertos_q <= '0;
      p1_q      <= '0;
      p2_q      <= '0;
`ifdef LOTERIA_TIMEOUT_EN
      wd_q      <= '0;
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      ptr_q     <= ptr_d;
      pos_q     <= pos_d;
      match_q   <= match_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      premio_q  <= premio_d;
      acertos_q <= acertos_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
`ifdef LOTERIA_TIMEOUT_EN
      wd_q      <= wd_d;
      aborted_q <= aborted_d;
`endif
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign premio  = premio_q;
  assign acertos = acertos_q;
  assign p1      = p1_q;
  assign p2      = p2_q;
`ifdef LOTERIA_TIMEOUT_EN
  assign aborted = aborted_q;
`else
  assign aborted = 1'b0;
`endif

endmodule

// File: tb/tb_loteria_arbitro.sv
// Bench for loteria_arbitro: terminal agents drive bets; a bet-level model predicts every output.
`timescale 1ns/1ps
module tb_loteria_arbitro;

  localparam int N   = 2;
  localparam int DW  = 4;
  localparam int CW  = 5;
  localparam int TMO = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N*DW-1:0] dig_in = '0;
  logic [N-1:0]  dig_vld = '0;
  logic          clr_cnt = 1'b0;
  logic [N-1:0]  grant;
  logic          busy, done, aborted;
  logic [1:0]    premio;
  logic [2:0]    acertos;
  logic [CW-1:0] p1, p2;

  loteria_arbitro #(.N_TERM(N), .DIGIT_W(DW), .CNT_W(CW), .DRAW(20'h53820), .TIMEOUT_CYC(TMO)) dut (
    .clock(clock), .reset(reset), .req(req), .dig_in(dig_in), .dig_vld(dig_vld),
    .clr_cnt(clr_cnt), .grant(grant), .busy(busy), .done(done), .premio(premio),
    .acertos(acertos), .p1(p1), .p2(p2), .aborted(aborted));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int draw_d[5] = '{5, 3, 8, 2, 0};

  // Bet-level model state
  int m_phase, m_g, m_ptr, m_p1, m_p2, m_premio, m_acertos, m_done, m_abort, m_wd;
  int m_digs[$];

  // Terminal agents
  int t_act[N], t_pos[N], t_drop[N], t_wait[N], t_rearm[N], t_vldp[N];
  int t_bet[N][5];
  int rand_mode = 0, clr_force = 0, clr_on_eval = 0;

  int cyc = 0, done_cnt = 0, done_at = 0, ab_cnt = 0, last_g = 0, req_at = 0;
  logic [N-1:0] prev_grant = '0;
  int glog[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Score from the rules: per-position equality, longest all-matching window.
  function automatic void score(input int d[5], output int pr, output int ac);
    int m[5];
    int best;
    ac = 0;
    best = 0;
    for (int k = 0; k < 5; k++) begin
      m[k] = (d[k] <= 9 && d[k] == draw_d[k]) ? 1 : 0;
      ac += m[k];
    end
    for (int s = 0; s < 5; s++)
      for (int l = 1; s + l <= 5; l++) begin
        int all = 1;
        for (int t = s; t < s + l; t++) all &= m[t];
        if (all == 1 && l > best) best = l;
      end
    pr = (best >= 4) ? 1 : (best >= 2) ? 2 : 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_g = 0; m_ptr = 0; m_p1 = 0; m_p2 = 0; m_premio = 0;
    m_acertos = 0; m_done = 0; m_abort = 0; m_wd = 0;
    m_digs.delete();
  endtask

  task automatic model_step();
    m_done = 0;
    m_abort = 0;
    if (m_phase == 0) begin
      if (req != 0) begin
        for (int k = N - 1; k >= 0; k--)
          if (req[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
        m_phase = 1;
        m_wd = 0;
        m_digs.delete();
      end
    end else if (m_phase == 1) begin
      if (!req[m_g]) begin
        m_phase = 0;
        m_ptr = (m_g + 1) % N;
      end else if (dig_vld[m_g]) begin
        m_digs.push_back(int'(dig_in[m_g*DW +: DW]));
        m_wd = 0;
        if (m_digs.size() == 5) m_phase = 2;
      end else begin
`ifdef LOTERIA_TIMEOUT_EN
        m_wd++;
        if (m_wd == TMO) begin
          m_abort = 1;
          m_phase = 0;
          m_ptr = (m_g + 1) % N;
        end
`endif
      end
    end else begin
      int a[5];
      int pr, ac;
      for (int k = 0; k < 5; k++) a[k] = m_digs[k];
      score(a, pr, ac);
      m_premio = pr;
      m_acertos = ac;
      m_done = 1;
      if (pr == 1 && m_p1 < CMAX) m_p1++;
      if (pr == 2 && m_p2 < CMAX) m_p2++;
      m_ptr = (m_g + 1) % N;
      m_phase = 0;
    end
    if (clr_cnt) begin
      m_p1 = 0;
      m_p2 = 0;
    end
  endtask

  task automatic check_outputs();
    chk("grant", int'(grant), (m_phase == 1) ? (1 << m_g) : 0);
    chk("busy", int'(busy), (m_phase != 0) ? 1 : 0);
    chk("done", int'(done), m_done);
    chk("premio", int'(premio), m_premio);
    chk("acertos", int'(acertos), m_acertos);
    chk("p1", int'(p1), m_p1);
    chk("p2", int'(p2), m_p2);
    chk("aborted", int'(aborted), m_abort);
  endtask

  task automatic set_bet(input int i, input logic [19:0] v, input int drop);
    for (int k = 0; k < 5; k++) t_bet[i][k] = int'(v[19-4*k -: 4]);
    t_drop[i] = drop; t_pos[i] = 0; t_wait[i] = 0; t_vldp[i] = 100; t_act[i] = 1;
  endtask

  task automatic rand_bet(input int i);
    for (int k = 0; k < 5; k++)
      t_bet[i][k] = ($urandom_range(99) < 65) ? draw_d[k] : int'($urandom_range(15));
    t_drop[i] = ($urandom_range(7) == 0) ? int'($urandom_range(4)) : -1;
    t_pos[i] = 0; t_wait[i] = 0; t_vldp[i] = 50 + int'($urandom_range(50)); t_act[i] = 1;
  endtask

  task automatic drive_terminals();
    logic [N-1:0] r, v;
    logic [N*DW-1:0] d;
    r = '0; v = '0; d = '0;
    for (int i = 0; i < N; i++) begin
      int dropped = 0;
      if (done && t_wait[i] != 0) begin
        t_wait[i] = 0;
        t_act[i] = t_rearm[i];
        if (t_rearm[i] != 0) set_bet(i, 20'h53820, -1);
      end
      if (aborted && t_act[i] != 0 && t_wait[i] == 0 && last_g == i) begin
        t_act[i] = 0; dropped = 1;
      end
      if (t_act[i] != 0 && t_wait[i] == 0 && grant[i] && t_drop[i] == t_pos[i]) begin
        t_act[i] = 0; dropped = 1;
      end
      if (t_act[i] == 0 && dropped == 0 && rand_mode != 0 && $urandom_range(99) < 25)
        rand_bet(i);
      r[i] = (t_act[i] != 0);
      if (t_act[i] != 0 && t_wait[i] == 0) begin
        v[i] = ($urandom_range(99) < t_vldp[i]);
        d[i*DW +: DW] = DW'(t_bet[i][t_pos[i]]);
      end else begin
        v[i] = (rand_mode != 0) ? 1'($urandom_range(1)) : 1'b0;
        d[i*DW +: DW] = DW'($urandom_range(15));
      end
      if (grant[i] && r[i] && v[i] && t_wait[i] == 0 && t_pos[i] < 5) begin
        t_pos[i]++;
        if (t_pos[i] == 5) t_wait[i] = 1;
      end
    end
    req = r;
    dig_vld = v;
    dig_in = d;
    clr_cnt = (clr_force != 0) || (clr_on_eval != 0 && m_phase == 2) ||
              (rand_mode != 0 && $urandom_range(63) == 0);
  endtask

  task automatic cycle();
    @(negedge clock);
    cyc++;
    if (done) begin done_cnt++; done_at = cyc; end
    if (aborted) ab_cnt++;
    if (grant != 0) last_g = grant[1] ? 1 : 0;
    if (grant != 0 && prev_grant == 0) glog.push_back(int'(grant));
    prev_grant = grant;
    check_outputs();
    drive_terminals();
    model_step();
  endtask

  task automatic wait_done(input string name, input int budget);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < budget) begin cycle(); n++; end
    if (done_cnt == start) timeout_fail(name);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((t_act[0] != 0 || t_act[1] != 0 || m_phase != 0) && n < budget) begin cycle(); n++; end
    if (n >= budget) timeout_fail(name);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "simulation time bound");
  end

  initial begin
    int start, n, sp;
    for (int i = 0; i < N; i++) begin
      t_act[i] = 0; t_pos[i] = 0; t_drop[i] = -1; t_wait[i] = 0; t_rearm[i] = 0; t_vldp[i] = 100;
    end
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst_grant", int'(grant), 0); chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);   chk("rst_premio", int'(premio), 0);
    chk("rst_acertos", int'(acertos), 0); chk("rst_p1", int'(p1), 0);
    chk("rst_p2", int'(p2), 0);       chk("rst_aborted", int'(aborted), 0);
    reset = 1'b0;

    // Full match on T0, continuous digits
    set_bet(0, 20'h53820, -1);
    req_at = cyc + 1;
    wait_done("t0_win", 40);
    chk("t0_latency", done_at - req_at, 7);
    chk("t0_premio", int'(premio), 1); chk("t0_acertos", int'(acertos), 5);
    chk("t0_p1", int'(p1), 1);         chk("t0_p2", int'(p2), 0);

    set_bet(1, 20'h53877, -1);
    wait_done("t1_p2", 40);
    chk("t1_premio", int'(premio), 2); chk("t1_acertos", int'(acertos), 3);
    chk("t1_p2", int'(p2), 1);

    set_bet(1, 20'h59890, -1);
    wait_done("t1_none", 40);
    chk("t1n_premio", int'(premio), 0); chk("t1n_acertos", int'(acertos), 3);

    // Both requesting continuously: alternation
    glog.delete();
    t_rearm[0] = 1; t_rearm[1] = 1;
    set_bet(0, 20'h53820, -1); set_bet(1, 20'h53820, -1);
    n = 0;
    while (glog.size() < 4 && n < 100) begin cycle(); n++; end
    t_rearm[0] = 0; t_rearm[1] = 0;
    drain("fair_drain", 100);
    if (glog.size() < 4) timeout_fail("fair_grants");
    else begin
      chk("fair_g0", glog[0], 1); chk("fair_g1", glog[1], 2);
      chk("fair_g2", glog[2], 1); chk("fair_g3", glog[3], 2);
    end
    chk("fair_p1", int'(p1), 6);

    // T1 no-prize bet leaves ptr at 0, then T0 abandons after 2 digits
    set_bet(1, 20'h59890, -1);
    wait_done("ptr_prep", 40);
    start = done_cnt;
    set_bet(0, 20'h53820, 2);
    n = 0;
    while (t_act[0] != 0 && n < 30) begin cycle(); n++; end
    repeat (3) cycle();
    chk("drop_no_done", done_cnt - start, 0);
    chk("drop_p1", int'(p1), 6); chk("drop_p2", int'(p2), 1);
    glog.delete();
    set_bet(0, 20'h53820, -1); set_bet(1, 20'h53820, -1);
    n = 0;
    while (glog.size() < 1 && n < 20) begin cycle(); n++; end
    if (glog.size() < 1) timeout_fail("drop_next");
    else chk("drop_next_grant", glog[0], 2);
    drain("drop_drain", 100);

    // Saturation and clear-wins-over-increment
    clr_force = 1; cycle(); clr_force = 0;
    for (int b = 0; b < 32; b++) begin
      set_bet(0, 20'h53820, -1);
      wait_done("sat_bet", 40);
    end
    chk("sat_p1", int'(p1), 31); chk("sat_p2", int'(p2), 0);
    clr_on_eval = 1;
    set_bet(0, 20'h53820, -1);
    wait_done("clr_bet", 40);
    clr_on_eval = 0;
    chk("clr_p1", int'(p1), 0); chk("clr_premio", int'(premio), 1);

    // Granted terminal goes silent
    sp = ab_cnt; start = done_cnt;
    set_bet(0, 20'h53820, -1);
    t_vldp[0] = 0;
    repeat (20) cycle();
`ifdef LOTERIA_TIMEOUT_EN
    chk("tmo_aborted", ab_cnt - sp, 1);
    chk("tmo_grant", int'(grant), 0);
    chk("tmo_no_done", done_cnt - start, 0);
`else
    chk("notmo_grant", int'(grant), 1);
    chk("notmo_busy", int'(busy), 1);
    chk("notmo_aborted", ab_cnt - sp, 0);
`endif
    t_act[0] = 0;
    drain("tmo_drain", 20);

    // Randomized traffic
    rand_mode = 1;
    repeat (2500) cycle();
    rand_mode = 0;
    drain("rand_drain", 300);

    // Async reset in the middle of a bet
    set_bet(1, 20'h53877, -1);
    n = 0;
    while (t_pos[1] < 2 && n < 20) begin cycle(); n++; end
    reset = 1'b1;
    #1;
    chk("arst_grant", int'(grant), 0); chk("arst_busy", int'(busy), 0);
    chk("arst_p1", int'(p1), 0);       chk("arst_p2", int'(p2), 0);
    chk("arst_premio", int'(premio), 0);
    for (int i = 0; i < N; i++) begin t_act[i] = 0; t_wait[i] = 0; t_pos[i] = 0; end
    req = '0; dig_vld = '0; clr_cnt = 1'b0;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    start = done_cnt;
    set_bet(1, 20'h53877, -1);
    wait_done("arst_rebet", 40);
    chk("arst_rebet_p2", int'(p2), 1); chk("arst_rebet_p1", int'(p1), 0);
    repeat (2) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
